// File: rtl/instr_encoder.sv
// instr_encoder
//   Turns an instruction id plus operand fields into a 32-bit RV64IM word.
//   Each request is legality-checked and encoded combinationally. Legal words
//   go into a DEPTH-entry FIFO. Illegal requests complete the handshake but are
//   dropped, and they are reported through err_illegal/err_count.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  request handshake (in_ready = occupancy < DEPTH)
//   in_instr_id     7-bit instruction code (table below)
//   in_rd/rs1/rs2   register fields (rs1 carries zimm for csrr*i)
//   in_imm          sign-extended immediate; CSR address in [11:0]; shamt in [5:0]
//   out_valid/ready FIFO head handshake
//   out_instr       word at FIFO head (0 when empty)
//   err_illegal     one-cycle pulse after an illegal request was accepted
//   err_count       saturating count of illegal requests
module instr_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_instr_id,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             err_illegal,
    output logic [CNT_W-1:0] err_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    // Instruction ids, matching the decoder's code table.
    localparam logic [6:0] I_INVALID = 7'd0,
        I_LUI = 7'd1, I_AUIPC = 7'd2, I_JAL = 7'd3, I_JALR = 7'd4,
        I_BEQ = 7'd5, I_BNE = 7'd6, I_BLT = 7'd7, I_BGE = 7'd8, I_BLTU = 7'd9, I_BGEU = 7'd10,
        I_LB = 7'd11, I_LH = 7'd12, I_LW = 7'd13, I_LD = 7'd14, I_LBU = 7'd15, I_LHU = 7'd16,
        I_LWU = 7'd17,
        I_SB = 7'd18, I_SH = 7'd19, I_SW = 7'd20, I_SD = 7'd21,
        I_ADDI = 7'd22, I_SLTI = 7'd23, I_SLTIU = 7'd24, I_XORI = 7'd25, I_ORI = 7'd26,
        I_ANDI = 7'd27, I_SLLI = 7'd28, I_SRLI = 7'd29, I_SRAI = 7'd30,
        I_ADD = 7'd31, I_SUB = 7'd32, I_SLL = 7'd33, I_SLT = 7'd34, I_SLTU = 7'd35,
        I_XOR = 7'd36, I_SRL = 7'd37, I_SRA = 7'd38, I_OR = 7'd39, I_AND = 7'd40,
        I_ADDIW = 7'd41, I_SLLIW = 7'd42, I_SRLIW = 7'd43, I_SRAIW = 7'd44,
        I_ADDW = 7'd45, I_SUBW = 7'd46, I_SLLW = 7'd47, I_SRLW = 7'd48, I_SRAW = 7'd49,
        I_MUL = 7'd50, I_MULH = 7'd51, I_MULHSU = 7'd52, I_MULHU = 7'd53,
        I_DIV = 7'd54, I_DIVU = 7'd55, I_REM = 7'd56, I_REMU = 7'd57,
        I_MULW = 7'd58, I_DIVW = 7'd59, I_DIVUW = 7'd60, I_REMW = 7'd61, I_REMUW = 7'd62,
        I_FENCE = 7'd63, I_ECALL = 7'd64, I_EBREAK = 7'd65,
        I_CSRRW = 7'd66, I_CSRRS = 7'd67, I_CSRRC = 7'd68,
        I_CSRRWI = 7'd69, I_CSRRSI = 7'd70, I_CSRRCI = 7'd71,
        I_BUBBLE = 7'd72;

    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111,
        OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011,
        OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011,
        OPC_OP = 7'b0110011, OPC_OPIMM32 = 7'b0011011, OPC_OP32 = 7'b0111011,
        OPC_FENCE = 7'b0001111, OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_ALT = 7'b0100000, F7_MUL = 7'b0000001;

    typedef enum logic [3:0] {
        FMT_BAD, FMT_R, FMT_I, FMT_SH, FMT_SHW, FMT_S, FMT_B, FMT_U, FMT_J, FMT_FIX
    } fmt_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // ---- stage p0: combinational decode, legality and encode ----
    fmt_t               fmt_p0;
    logic [6:0]         opc_p0;
    logic [2:0]         f3_p0;
    logic [6:0]         f7_p0;
    logic [31:0]        fix_p0;
    logic               legal_p0;
    logic [31:0]        word_p0;
    logic signed [31:0] imm_s;
    logic               i_ok, b_ok, j_ok;

    assign imm_s = in_imm;
    assign i_ok  = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    assign b_ok  = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !in_imm[0];
    assign j_ok  = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !in_imm[0];

    always_comb begin
        fmt_p0 = FMT_BAD;
        opc_p0 = 7'd0;
        f3_p0  = 3'd0;
        f7_p0  = 7'd0;
        fix_p0 = 32'd0;
        case (in_instr_id)
            I_LUI:    begin fmt_p0 = FMT_U; opc_p0 = OPC_LUI; end
            I_AUIPC:  begin fmt_p0 = FMT_U; opc_p0 = OPC_AUIPC; end
            I_JAL:    begin fmt_p0 = FMT_J; opc_p0 = OPC_JAL; end
            I_JALR:   begin fmt_p0 = FMT_I; opc_p0 = OPC_JALR; end
            I_BEQ:    begin fmt_p0 = FMT_B; opc_p0 = OPC_BRANCH; f3_p0 = 3'd0; end
            I_BNE:    begin fmt_p0 = FMT_B; opc_p0 = OPC_BRANCH; f3_p0 = 3'd1; end
            I_BLT:    begin fmt_p0 = FMT_B; opc_p0 = OPC_BRANCH; f3_p0 = 3'd4; end
            I_BGE:    begin fmt_p0 = FMT_B; opc_p0 = OPC_BRANCH; f3_p0 = 3'd5; end
            I_BLTU:   begin fmt_p0 = FMT_B; opc_p0 = OPC_BRANCH; f3_p0 = 3'd6; end
            I_BGEU:   begin fmt_p0 = FMT_B; opc_p0 = OPC_BRANCH; f3_p0 = 3'd7; end
            I_LB:     begin fmt_p0 = FMT_I; opc_p0 = OPC_LOAD; f3_p0 = 3'd0; end
            I_LH:     begin fmt_p0 = FMT_I; opc_p0 = OPC_LOAD; f3_p0 = 3'd1; end
            I_LW:     begin fmt_p0 = FMT_I; opc_p0 = OPC_LOAD; f3_p0 = 3'd2; end
            I_LD:     begin fmt_p0 = FMT_I; opc_p0 = OPC_LOAD; f3_p0 = 3'd3; end
            I_LBU:    begin fmt_p0 = FMT_I; opc_p0 = OPC_LOAD; f3_p0 = 3'd4; end
            I_LHU:    begin fmt_p0 = FMT_I; opc_p0 = OPC_LOAD; f3_p0 = 3'd5; end
            I_LWU:    begin fmt_p0 = FMT_I; opc_p0 = OPC_LOAD; f3_p0 = 3'd6; end
            I_SB:     begin fmt_p0 = FMT_S; opc_p0 = OPC_STORE; f3_p0 = 3'd0; end
            I_SH:     begin fmt_p0 = FMT_S; opc_p0 = OPC_STORE; f3_p0 = 3'd1; end
            I_SW:     begin fmt_p0 = FMT_S; opc_p0 = OPC_STORE; f3_p0 = 3'd2; end
            I_SD:     begin fmt_p0 = FMT_S; opc_p0 = OPC_STORE; f3_p0 = 3'd3; end
            I_ADDI:   begin fmt_p0 = FMT_I; opc_p0 = OPC_OPIMM; f3_p0 = 3'd0; end
            I_SLTI:   begin fmt_p0 = FMT_I; opc_p0 = OPC_OPIMM; f3_p0 = 3'd2; end
            I_SLTIU:  begin fmt_p0 = FMT_I; opc_p0 = OPC_OPIMM; f3_p0 = 3'd3; end
            I_XORI:   begin fmt_p0 = FMT_I; opc_p0 = OPC_OPIMM; f3_p0 = 3'd4; end
            I_ORI:    begin fmt_p0 = FMT_I; opc_p0 = OPC_OPIMM; f3_p0 = 3'd6; end
            I_ANDI:   begin fmt_p0 = FMT_I; opc_p0 = OPC_OPIMM; f3_p0 = 3'd7; end
            I_SLLI:   begin fmt_p0 = FMT_SH; opc_p0 = OPC_OPIMM; f3_p0 = 3'd1; end
            I_SRLI:   begin fmt_p0 = FMT_SH; opc_p0 = OPC_OPIMM; f3_p0 = 3'd5; end
            I_SRAI:   begin fmt_p0 = FMT_SH; opc_p0 = OPC_OPIMM; f3_p0 = 3'd5; f7_p0 = F7_ALT; end
            I_ADD:    begin fmt_p0 = FMT_R; opc_p0 = OPC_OP; f3_p0 = 3'd0; end
            I_SUB:    begin fmt_p0 = FMT_R; opc_p0 = OPC_OP; f3_p0 = 3'd0; f7_p0 = F7_ALT; end
            I_SLL:    begin fmt_p0 = FMT_R; opc_p0 = OPC_OP; f3_p0 = 3'd1; end
            I_SLT:    begin fmt_p0 = FMT_R; opc_p0 = OPC_OP; f3_p0 = 3'd2; end
            I_SLTU:   begin fmt_p0 = FMT_R; opc_p0 = OPC_OP; f3_p0 = 3'd3; end
            I_XOR:    begin fmt_p0 = FMT_R; opc_p0 = OPC_OP; f3_p0 = 3'd4; end
            I_SRL:    begin fmt_p0 = FMT_R; opc_p0 = OPC_OP; f3_p0 = 3'd5; end
            I_SRA:    begin fmt_p0 = FMT_R; opc_p0 = OPC_OP; f3_p0 = 3'd5; f7_p0 = F7_ALT; end
            I_OR:     begin fmt_p0 = FMT_R; opc_p0 = OPC_OP; f3_p0 = 3'd6; end
            I_AND:    begin fmt_p0 = FMT_R; opc_p0 = OPC_OP; f3_p0 = 3'd7; end
            I_ADDIW:  begin fmt_p0 = FMT_I; opc_p0 = OPC_OPIMM32; f3_p0 = 3'd0; end
            I_SLLIW:  begin fmt_p0 = FMT_SHW; opc_p0 = OPC_OPIMM32; f3_p0 = 3'd1; end
            I_SRLIW:  begin fmt_p0 = FMT_SHW; opc_p0 = OPC_OPIMM32; f3_p0 = 3'd5; end
            I_SRAIW:  begin fmt_p0 = FMT_SHW; opc_p0 = OPC_OPIMM32; f3_p0 = 3'd5; f7_p0 = F7_ALT; end
            I_ADDW:   begin fmt_p0 = FMT_R; opc_p0 = OPC_OP32; f3_p0 = 3'd0; end
            I_SUBW:   begin fmt_p0 = FMT_R; opc_p0 = OPC_OP32; f3_p0 = 3'd0; f7_p0 = F7_ALT; end
            I_SLLW:   begin fmt_p0 = FMT_R; opc_p0 = OPC_OP32; f3_p0 = 3'd1; end
            I_SRLW:   begin fmt_p0 = FMT_R; opc_p0 = OPC_OP32; f3_p0 = 3'd5; end
            I_SRAW:   begin fmt_p0 = FMT_R; opc_p0 = OPC_OP32; f3_p0 = 3'd5; f7_p0 = F7_ALT; end
            I_MUL:    begin fmt_p0 = FMT_R; opc_p0 = OPC_OP; f3_p0 = 3'd0; f7_p0 = F7_MUL; end
            I_MULH:   begin fmt_p0 = FMT_R; opc_p0 = OPC_OP; f3_p0 = 3'd1; f7_p0 = F7_MUL; end
            I_MULHSU: begin fmt_p0 = FMT_R; opc_p0 = OPC_OP; f3_p0 = 3'd2; f7_p0 = F7_MUL; end
            I_MULHU:  begin fmt_p0 = FMT_R; opc_p0 = OPC_OP; f3_p0 = 3'd3; f7_p0 = F7_MUL; end
            I_DIV:    begin fmt_p0 = FMT_R; opc_p0 = OPC_OP; f3_p0 = 3'd4; f7_p0 = F7_MUL; end
            I_DIVU:   begin fmt_p0 = FMT_R; opc_p0 = OPC_OP; f3_p0 = 3'd5; f7_p0 = F7_MUL; end
            I_REM:    begin fmt_p0 = FMT_R; opc_p0 = OPC_OP; f3_p0 = 3'd6; f7_p0 = F7_MUL; end
            I_REMU:   begin fmt_p0 = FMT_R; opc_p0 = OPC_OP; f3_p0 = 3'd7; f7_p0 = F7_MUL; end
            I_MULW:   begin fmt_p0 = FMT_R; opc_p0 = OPC_OP32; f3_p0 = 3'd0; f7_p0 = F7_MUL; end
            I_DIVW:   begin fmt_p0 = FMT_R; opc_p0 = OPC_OP32; f3_p0 = 3'd4; f7_p0 = F7_MUL; end
            I_DIVUW:  begin fmt_p0 = FMT_R; opc_p0 = OPC_OP32; f3_p0 = 3'd5; f7_p0 = F7_MUL; end
            I_REMW:   begin fmt_p0 = FMT_R; opc_p0 = OPC_OP32; f3_p0 = 3'd6; f7_p0 = F7_MUL; end
            I_REMUW:  begin fmt_p0 = FMT_R; opc_p0 = OPC_OP32; f3_p0 = 3'd7; f7_p0 = F7_MUL; end
            I_FENCE:  begin fmt_p0 = FMT_I; opc_p0 = OPC_FENCE; f3_p0 = 3'd0; end
            I_ECALL:  begin fmt_p0 = FMT_FIX; fix_p0 = 32'h0000_0073; end
            I_EBREAK: begin fmt_p0 = FMT_FIX; fix_p0 = 32'h0010_0073; end
            // CSR ops share the I layout; the CSR address is not range-checked
            // as a signed immediate, so they use FMT_R-style unconditional
            // legality and are handled in the encoder below by opcode.
            I_CSRRW:  begin fmt_p0 = FMT_I; opc_p0 = OPC_SYSTEM; f3_p0 = 3'd1; end
            I_CSRRS:  begin fmt_p0 = FMT_I; opc_p0 = OPC_SYSTEM; f3_p0 = 3'd2; end
            I_CSRRC:  begin fmt_p0 = FMT_I; opc_p0 = OPC_SYSTEM; f3_p0 = 3'd3; end
            I_CSRRWI: begin fmt_p0 = FMT_I; opc_p0 = OPC_SYSTEM; f3_p0 = 3'd5; end
            I_CSRRSI: begin fmt_p0 = FMT_I; opc_p0 = OPC_SYSTEM; f3_p0 = 3'd6; end
            I_CSRRCI: begin fmt_p0 = FMT_I; opc_p0 = OPC_SYSTEM; f3_p0 = 3'd7; end
            I_BUBBLE: begin fmt_p0 = FMT_FIX; fix_p0 = 32'h0000_0000; end
            default:  fmt_p0 = FMT_BAD;
        endcase
    end

    always_comb begin
        legal_p0 = 1'b0;
        word_p0  = 32'd0;
        case (fmt_p0)
            FMT_R: begin
                legal_p0 = 1'b1;
                word_p0  = {f7_p0, in_rs2, in_rs1, f3_p0, in_rd, opc_p0};
            end
            FMT_I: begin
                legal_p0 = (opc_p0 == OPC_SYSTEM) ? 1'b1 : i_ok;
                word_p0  = {in_imm[11:0], in_rs1, f3_p0, in_rd, opc_p0};
            end
            FMT_SH: begin
                legal_p0 = (in_imm <= 32'd63);
                word_p0  = {f7_p0[6:1], in_imm[5:0], in_rs1, f3_p0, in_rd, opc_p0};
            end
            FMT_SHW: begin
                // imm <= 31 guarantees imm[5]=0, so the 6-bit shamt layout holds.
                legal_p0 = (in_imm <= 32'd31);
                word_p0  = {f7_p0[6:1], in_imm[5:0], in_rs1, f3_p0, in_rd, opc_p0};
            end
            FMT_S: begin
                legal_p0 = i_ok;
                word_p0  = {in_imm[11:5], in_rs2, in_rs1, f3_p0, in_imm[4:0], opc_p0};
            end
            FMT_B: begin
                legal_p0 = b_ok;
                word_p0  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3_p0,
                            in_imm[4:1], in_imm[11], opc_p0};
            end
            FMT_U: begin
                legal_p0 = (in_imm[11:0] == 12'd0);
                word_p0  = {in_imm[31:12], in_rd, opc_p0};
            end
            FMT_J: begin
                legal_p0 = j_ok;
                word_p0  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc_p0};
            end
            FMT_FIX: begin
                legal_p0 = 1'b1;
                word_p0  = fix_p0;
            end
            default: begin
                legal_p0 = 1'b0;
                word_p0  = 32'd0;
            end
        endcase
    end

    // ---- stage p1: output FIFO and error reporting ----
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    logic          accept, push, pop;

    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal_p0;
    assign pop       = out_valid && out_ready;
    // Gate the head word so an empty FIFO reads as zero without resetting storage.
    assign out_instr = out_valid ? mem[head] : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            err_illegal <= 1'b0;
            err_count   <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            err_illegal <= accept && !legal_p0;
            if (accept && !legal_p0) err_count <= sat_inc(err_count);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= word_p0;
    end

endmodule
